// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I size codes,
// response error codes, latched request payload and the accept-time request check.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RMW_READ,
    S_RMW_WRITE,
    S_RESP
  } state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  // Only the fields the datapath still needs after accept.
  typedef struct packed {
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } req_t;

  // Illegal size wins over misalignment.
  function automatic logic [1:0] check_req(input logic we, input logic [2:0] funct3,
                                           input logic [1:0] lane);
    logic [1:0] code;
    code = ERR_NONE;
    if (we ? (funct3 > F3_W) : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
      code = ERR_ILLEGAL;
    else if ((funct3 == F3_H || funct3 == F3_HU) && lane[0])
      code = ERR_MISALIGN;
    else if (funct3 == F3_W && lane != 2'b00)
      code = ERR_MISALIGN;
    return code;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-wide memory-access bus between the lsu (master) and the mmu (slave).
interface lsu_if;
  import lsu_pkg::*;

  logic [XLEN-1:0] virtual_addr;
  logic [XLEN-1:0] data_in;
  logic [XLEN-1:0] data_out;
  logic            mem_read;
  logic            mem_write;
  logic            mem_ready;

  modport master (
    output virtual_addr, data_in, mem_read, mem_write,
    input  data_out, mem_ready
  );

  modport slave (
    input  virtual_addr, data_in, mem_read, mem_write,
    output data_out, mem_ready
  );
endinterface

// File: rtl/lsu_align.sv
// Byte/half lane steering: load extract with sign/zero extension and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rword,
  input  logic [15:0]     wdata,
  input  logic [1:0]      lane,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rword[{lane, 3'b000} +: 8];
  assign half_sel = rword[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_data = rword;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = rword;
    endcase
  end

  // Untouched lanes of the old word pass through.
  always_comb begin
    merged = rword;
    case (funct3)
      F3_B:    merged[{lane, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    merged[{lane[1], 4'b0000} +: 16] = wdata;
      default: merged = rword;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one load or store per transaction toward the mmu, sub-word stores
// as read-modify-write. Define LSU_TIMEOUT_EN to bound strobes to TIMEOUT_CYCLES.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [1:0]      resp_err_code,
  lsu_if.master           mem
);

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  logic [XLEN-1:0] vaddr_d, din_d, rdata_d;
  logic            rvalid_d, err_d;
  logic [1:0]      code_d;
  logic [1:0]      req_code;
  logic [XLEN-1:0] load_data, merged;
  logic            timeout;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign req_code  = check_req(req_we, req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .rword     (mem.data_out),
    .wdata     (req_q.wdata),
    .lane      (req_q.lane),
    .funct3    (req_q.funct3),
    .load_data (load_data),
    .merged    (merged)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts strobe-high cycles without mem_ready; restarts on every state change.
  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if ((mem.mem_read || mem.mem_write) && !mem.mem_ready) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
      else                                     cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state_d != state_q) cnt_q <= '0;
    else                           cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cycles;
  assign timeout               = 1'b0;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    vaddr_d  = mem.virtual_addr;
    din_d    = mem.data_in;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    err_d    = 1'b0;
    code_d   = ERR_NONE;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d   = '{funct3: req_funct3, lane: req_addr[1:0], wdata: req_wdata[15:0]};
          vaddr_d = {req_addr[XLEN-1:2], 2'b00};
          if (req_code != ERR_NONE) begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            code_d   = req_code;
          end else if (!req_we) begin
            state_d = S_READ;
          end else if (req_funct3 == F3_W) begin
            state_d = S_WRITE;
            din_d   = req_wdata;
          end else begin
            state_d = S_RMW_READ;
          end
        end
      end
      S_READ: begin
        if (mem.mem_ready) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rdata_d  = load_data;
        end
      end
      S_RMW_READ: begin
        if (mem.mem_ready) begin
          state_d = S_RMW_WRITE;
          din_d   = merged;
        end
      end
      S_WRITE, S_RMW_WRITE: begin
        if (mem.mem_ready) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A timed-out RMW read skips its write phase.
    if (timeout) begin
      state_d  = S_RESP;
      rvalid_d = 1'b1;
      rdata_d  = '0;
      err_d    = 1'b1;
      code_d   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      req_q            <= '0;
      mem.virtual_addr <= '0;
      mem.data_in      <= '0;
      mem.mem_read     <= 1'b0;
      mem.mem_write    <= 1'b0;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      resp_err         <= 1'b0;
      resp_err_code    <= ERR_NONE;
    end else begin
      state_q          <= state_d;
      req_q            <= req_d;
      mem.virtual_addr <= vaddr_d;
      mem.data_in      <= din_d;
      mem.mem_read     <= (state_d == S_READ) || (state_d == S_RMW_READ);
      mem.mem_write    <= (state_d == S_WRITE) || (state_d == S_RMW_WRITE);
      resp_valid       <= rvalid_d;
      resp_rdata       <= rdata_d;
      resp_err         <= err_d;
      resp_err_code    <= code_d;
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the initiator side of the memory-access interface that the `mmu` answers. It accepts one load or store per transaction from the execute stage and decodes RV32I `funct3` sizes. It drives `virtual_addr`, `data_in`, `mem_read` and `mem_write` toward `mmu`, and waits on `mem_ready`. It returns sign- or zero-extended load data, and performs sub-word stores as a read-modify-write of the containing word.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum number of cycles a strobe may stay high without `mem_ready`. Used only with `LSU_TIMEOUT_EN`.

Ports:
- clk  in  1  clock. One clock domain.
- rst  in  1  reset. Synchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when high together with `req_valid` at a rising edge.
- req_we  in  1  0 = load, 1 = store.
- req_funct3  in  3  RV32I size/sign field: LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, valid while `resp_valid` is high; 0 for stores and errors.
- resp_err  out  1  transaction failed.
- resp_err_code  out  2  01 misaligned, 10 timeout, 11 illegal `funct3`, 00 none.
- virtual_addr  out  32  word address to `mmu`: `{req_addr[31:2],2'b00}`.
- data_in  out  32  write word to `mmu`.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- data_out  in  32  read word from `mmu`.
- mem_ready  in  1  `mmu` completion. Sampled only while a strobe is high.

## Operation
- States: IDLE, READ, WRITE, RMW_READ, RMW_WRITE, RESP.
- IDLE:
  - `req_ready = (state==IDLE) && !rst`.
  - On accept, the request fields are latched and checked.
- Check on accept:
  - Illegal `funct3`: loads 3/6/7, stores 3–7. Next state RESP, code 11.
  - Misaligned: halfword with `addr[0]`, or word with `addr[1:0]!=0`. Next state RESP, code 01.
  - Otherwise:
    - Load → READ.
    - SW → WRITE.
    - SB/SH → RMW_READ.
- READ / RMW_READ:
  - `mem_read=1`. `virtual_addr` is held stable.
  - On an edge with `mem_ready=1`, the read word is captured.
  - READ → RESP. RMW_READ → RMW_WRITE.
- RMW_WRITE / WRITE:
  - `mem_write=1`.
  - `data_in` is the merged word (RMW) or `req_wdata` (SW).
  - On an edge with `mem_ready=1` → RESP.
- RESP:
  - `resp_valid=1` for exactly one cycle, then IDLE.
  - `req_ready` stays 0 in this state.
- Load extraction:
  - Byte lane is `addr[1:0]`. LB sign-extends `data_out[8*lane+:8]`; LBU zero-extends it.
  - Half lane is `addr[1]`. LH sign-extends the half; LHU zero-extends it.
  - LW returns the word unchanged.
- Store merge:
  - SB replaces byte `addr[1:0]` of the read word with `req_wdata[7:0]`.
  - SH replaces half `addr[1]` with `req_wdata[15:0]`.
  - All other bytes are preserved.
- Strobes:
  - `mem_read` and `mem_write` are never high together.
  - `mem_ready` is ignored when no strobe is high.

## Timing
- Reset values:
  - State IDLE.
  - `resp_valid`, `resp_err`, `resp_err_code`, `resp_rdata`, `virtual_addr`, `data_in`, `mem_read`, `mem_write` all 0.
  - `req_ready` is 0 while `rst` is high and 1 on the first cycle after.
- Reset mid-transaction:
  - Strobes drop on the next edge.
  - No response is produced.
  - The in-flight request is discarded.
- Latency, with the request accepted at edge N:
  - The strobe rises in cycle N+1.
  - With zero-wait `mem_ready`: `resp_valid` in cycle N+2 for load/SW, N+3 for SB/SH.
  - Error responses from the check: `resp_valid` in cycle N+1 with no strobe.
- Wait states: each cycle that `mem_ready` stays low adds one cycle.
- RMW_READ → RMW_WRITE: `mem_read` falls and `mem_write` rises in the same cycle, with no idle gap.
- Back-to-back requests: the minimum issue interval is latency+1, because RESP blocks `req_ready`.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A counter clears on entry to each strobe state and increments every cycle the strobe is high.
  - When it reaches TIMEOUT_CYCLES without `mem_ready`, the strobe drops, the state moves to RESP, and the response is code 10 with `resp_rdata=0`.
  - For RMW, a timeout in the read phase skips the write.
- `LSU_TIMEOUT_EN` undefined: no counter; the unit waits indefinitely and code 10 is never produced.

## Structure
- `lsu_pkg`:
  - State enum.
  - `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - Error-code constants.
- Sub-module `lsu_align`, purely combinational:
  - Load extract/extend from (word, `addr[1:0]`, `funct3`).
  - Store merge from (old word, wdata, `addr[1:0]`, `funct3`).
- The FSM, request latches and timeout counter stay in `lsu`.

## Test plan
- SW to 0x28 with wdata 42, then LW from 0x28, against a zero-wait memory model → write strobe seen with `virtual_addr=0x28`, `data_in=42`; load returns 42, `resp_err=0`.
- Memory word 0x80 = 0x8001_7F00, then LB 0x81, LBU 0x83, LH 0x82, LHU 0x82 → results 0x0000_007F, 0x0000_0080, 0xFFFF_8001, 0x0000_8001.
- Word 0x40 = 0x1122_3344, then SB 0x42 with wdata 0xAA → read then write of word 0x40 with `data_in=0x11AA_3344`; `resp_valid` at N+3.
- LH 0x41 and SW 0x42 → `resp_err=1`, code 01, no strobe, `resp_valid` at N+1. Load with `funct3=3` → code 11.
- `mem_ready` delayed 5 cycles → strobe held 6 cycles with stable address; `resp_valid` at N+7. With `LSU_TIMEOUT_EN` and TIMEOUT_CYCLES=8, `mem_ready` never asserted → strobe drops after 8 cycles, code 10.
- `rst` pulsed while in RMW_READ → strobes 0 on the next cycle, no `resp_valid`, `req_ready=1` after `rst` is released.
